id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  decode stage presents an instruction.
REQ-005 SHALL have port in_ready  output  1  this stage accepts the presented instruction this cycle.
REQ-006 SHALL have port in_alu_ctrl  input  3  ALU operation code (000 add, 001 sub, 010 and, 011 or, 100 xor).
REQ-007 SHALL have ports in_rs1, in_rs2, in_rd  input  5 each  source/destination register indices.
REQ-008 SHALL have ports in_rs1_data, in_rs2_data, in_imm  input  DATA_WIDTH each  register-file read data and sign-extended immediate.
REQ-009 SHALL have port in_alu_src  input  1  1 selects in_imm as operand 2, 0 selects rs2 data.
REQ-010 SHALL have port in_reg_write  input  1  instruction writes in_rd.
REQ-011 SHALL have port flush  input  1  discard held and incoming instruction.
REQ-012 SHALL have ports fwd_ex_valid  input  1, fwd_ex_rd  input  5, fwd_ex_data  input  DATA_WIDTH  younger in-flight result.
REQ-013 SHALL have ports fwd_wb_valid  input  1, fwd_wb_rd  input  5, fwd_wb_data  input  DATA_WIDTH  writeback result.
REQ-014 SHALL have port out_valid  output  1  ALU inputs hold a valid instruction.
REQ-015 SHALL have port out_ready  input  1  ALU/downstream consumes this cycle.
REQ-016 SHALL have ports ALUctrl  output  3, ALUop1  output  DATA_WIDTH, ALUop2  output  DATA_WIDTH  registered ALU inputs.
REQ-017 SHALL have ports out_rd  output  5, out_reg_write  output  1  registered destination info.

Function
REQ-018 in_ready SHALL equal (!out_valid || out_ready), combinational.
REQ-019 Accept = in_valid && in_ready; on accept all outputs SHALL load at the next rising edge (latency 1 cycle); out_valid SHALL become 1.
REQ-020 out_valid && out_ready without accept SHALL clear out_valid next cycle; data registers SHALL hold.
REQ-021 out_valid && !out_ready (stall) SHALL hold all outputs unchanged except operand refresh per REQ-025.
REQ-022 Simultaneous consume and accept SHALL replace the entry back-to-back with no bubble.
REQ-023 flush SHALL clear out_valid next cycle, overriding accept; incoming beat counts as accepted and is discarded; out_reg_write SHALL be 0 next cycle.
REQ-024 Operand resolution for rs (rs1, or rs2 when in_alu_src=0): if rs != 0 and fwd_ex_valid and fwd_ex_rd == rs use fwd_ex_data; else if rs != 0 and fwd_wb_valid and fwd_wb_rd == rs use fwd_wb_data; else register-file data.
REQ-025 During stall, the stored rs1/rs2 indices SHALL be re-resolved each cycle per REQ-024 and ALUop1/ALUop2 updated on a match; immediate operand never refreshed.
REQ-026 Index 0 SHALL never forward; operand for rs=0 SHALL be the supplied data (0 from register file).
REQ-027 When in_alu_src=1, ALUop2 SHALL be in_imm, unmodified.
REQ-028 No arithmetic performed; widths pass through unchanged.

Reset
REQ-029 rst=1 at a rising edge SHALL set out_valid=0, ALUctrl=0, ALUop1=0, ALUop2=0, out_rd=0, out_reg_write=0, stored rs indices=0, overriding flush and accept.
REQ-030 Reset mid-stall SHALL discard the held instruction; in_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-031 Macro ID_EX_FWD_EN defined: forwarding per REQ-024/025 active.
REQ-032 Macro ID_EX_FWD_EN undefined: fwd_* ports present but ignored; operands taken from register-file data only; no stall refresh.

Verification
REQ-033 Reset then in_valid=1, add, rs1_data=5, rs2_data=7, alu_src=0, out_ready=1 -> next cycle out_valid=1, ALUctrl=000, ALUop1=5, ALUop2=7.
REQ-034 out_ready=0 with entry held, new in_valid=1 -> in_ready=0, outputs unchanged 3 cycles; out_ready=1 -> new entry loads next cycle, no bubble.
REQ-035 FWD_EN: rs1=3, rs1_data=1, fwd_ex(rd=3,data=0xAA), fwd_wb(rd=3,data=0xBB) -> ALUop1=0xAA; with fwd_ex_valid=0 -> 0xBB; rs1=0 with fwd rd=0 -> ALUop1=0.
REQ-036 FWD_EN stall: held rs2=4, fwd_wb(rd=4,data=0x1234) pulsed one cycle -> ALUop2=0x1234 next cycle and retained.
REQ-037 flush with in_valid=1 and held entry -> next cycle out_valid=0, out_reg_write=0; rst asserted same cycle as accept -> all outputs 0.
REQ-038 Without FWD_EN: scenario REQ-035 -> ALUop1=1.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with valid/ready handshake, flush and operand forwarding.
// Define ID_EX_FWD_EN to enable EX/WB forwarding and stall-time operand refresh.
module id_ex_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_alu_ctrl,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [4:0]            in_rd,
  input  logic [DATA_WIDTH-1:0] in_rs1_data,
  input  logic [DATA_WIDTH-1:0] in_rs2_data,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic                  in_alu_src,
  input  logic                  in_reg_write,
  input  logic                  flush,
  input  logic                  fwd_ex_valid,
  input  logic [4:0]            fwd_ex_rd,
  input  logic [DATA_WIDTH-1:0] fwd_ex_data,
  input  logic                  fwd_wb_valid,
  input  logic [4:0]            fwd_wb_rd,
  input  logic [DATA_WIDTH-1:0] fwd_wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0]            ALUctrl,
  output logic [DATA_WIDTH-1:0] ALUop1,
  output logic [DATA_WIDTH-1:0] ALUop2,
  output logic [4:0]            out_rd,
  output logic                  out_reg_write
);

  logic                  accept;
  logic                  consume;
  logic [DATA_WIDTH-1:0] op1_p0;
  logic [DATA_WIDTH-1:0] op2_p0;
  logic [DATA_WIDTH-1:0] op1_hold;
  logic [DATA_WIDTH-1:0] op2_hold;
  logic [4:0]            rs1_p1;
  logic [4:0]            rs2_p1;
  logic                  imm_sel_p1;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

`ifdef ID_EX_FWD_EN
  // EX result is younger than WB, so it wins; x0 is hard-wired and never forwarded.
  function automatic logic [DATA_WIDTH-1:0] resolve(
    input logic [4:0]            rs,
    input logic [DATA_WIDTH-1:0] dflt,
    input logic                  ex_v,
    input logic [4:0]            ex_rd,
    input logic [DATA_WIDTH-1:0] ex_d,
    input logic                  wb_v,
    input logic [4:0]            wb_rd,
    input logic [DATA_WIDTH-1:0] wb_d
  );
    if (rs != 5'd0 && ex_v && ex_rd == rs)      return ex_d;
    else if (rs != 5'd0 && wb_v && wb_rd == rs) return wb_d;
    else                                        return dflt;
  endfunction

  always_comb begin
    op1_p0   = resolve(in_rs1, in_rs1_data, fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
                       fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
    op2_p0   = in_alu_src ? in_imm
             : resolve(in_rs2, in_rs2_data, fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
                       fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
    op1_hold = resolve(rs1_p1, ALUop1, fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
                       fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
    op2_hold = imm_sel_p1 ? ALUop2
             : resolve(rs2_p1, ALUop2, fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
                       fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_ex_valid, fwd_ex_rd, fwd_ex_data, fwd_wb_valid,
                        fwd_wb_rd, fwd_wb_data, rs1_p1, rs2_p1, imm_sel_p1};

  always_comb begin
    op1_p0   = in_rs1_data;
    op2_p0   = in_alu_src ? in_imm : in_rs2_data;
    op1_hold = ALUop1;
    op2_hold = ALUop2;
  end
`endif

  // ---- decode -> execute boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      ALUctrl       <= 3'd0;
      ALUop1        <= '0;
      ALUop2        <= '0;
      out_rd        <= 5'd0;
      out_reg_write <= 1'b0;
      rs1_p1        <= 5'd0;
      rs2_p1        <= 5'd0;
      imm_sel_p1    <= 1'b0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      ALUctrl       <= in_alu_ctrl;
      ALUop1        <= op1_p0;
      ALUop2        <= op2_p0;
      out_rd        <= in_rd;
      out_reg_write <= in_reg_write;
      rs1_p1        <= in_rs1;
      rs2_p1        <= in_rs2;
      imm_sel_p1    <= in_alu_src;
    end else if (consume) begin
      out_valid     <= 1'b0;
    end else if (out_valid) begin
      ALUop1        <= op1_hold;
      ALUop2        <= op2_hold;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized + directed bench for id_ex_reg against a behavioural model of the stage.
// Follows ID_EX_FWD_EN the same way the design does.
module tb_id_ex_reg;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_alu_src, in_reg_write, flush, out_ready;
  logic          fwd_ex_valid, fwd_wb_valid;
  logic [2:0]    in_alu_ctrl;
  logic [4:0]    in_rs1, in_rs2, in_rd, fwd_ex_rd, fwd_wb_rd;
  logic [DW-1:0] in_rs1_data, in_rs2_data, in_imm, fwd_ex_data, fwd_wb_data;
  logic          in_ready, out_valid, out_reg_write;
  logic [2:0]    ALUctrl;
  logic [DW-1:0] ALUop1, ALUop2;
  logic [4:0]    out_rd;

  int n_checks = 0;
  int n_pass   = 0;

  // model state: what the stage should be holding
  logic          m_valid, m_rw, m_imm;
  logic [2:0]    m_ctrl;
  logic [DW-1:0] m_op1, m_op2;
  logic [4:0]    m_rd, m_rs1, m_rs2;

  id_ex_reg #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_ctrl(in_alu_ctrl), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_alu_src(in_alu_src), .in_reg_write(in_reg_write), .flush(flush),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .ALUctrl(ALUctrl),
    .ALUop1(ALUop1), .ALUop2(ALUop2), .out_rd(out_rd), .out_reg_write(out_reg_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Operand value the spec's forwarding rule yields; dflt when nothing matches.
  function automatic logic [DW-1:0] pick(input logic [4:0] rs, input logic [DW-1:0] dflt);
`ifdef ID_EX_FWD_EN
    if (rs == 0) return dflt;
    if (fwd_ex_valid && fwd_ex_rd == rs) return fwd_ex_data;
    if (fwd_wb_valid && fwd_wb_rd == rs) return fwd_wb_data;
`endif
    return dflt;
  endfunction

  task automatic model_edge();
    logic acc;
    acc = in_valid && (!m_valid || out_ready);
    if (rst) begin
      {m_valid, m_rw, m_imm, m_ctrl, m_rd, m_rs1, m_rs2} = '0;
      m_op1 = '0; m_op2 = '0;
    end else if (flush) begin
      m_valid = 0; m_rw = 0;
    end else if (acc) begin
      m_valid = 1; m_ctrl = in_alu_ctrl; m_rd = in_rd; m_rw = in_reg_write;
      m_op1 = pick(in_rs1, in_rs1_data);
      m_op2 = in_alu_src ? in_imm : pick(in_rs2, in_rs2_data);
      m_rs1 = in_rs1; m_rs2 = in_rs2; m_imm = in_alu_src;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end else if (m_valid) begin
      m_op1 = pick(m_rs1, m_op1);
      if (!m_imm) m_op2 = pick(m_rs2, m_op2);
    end
  endtask

  // One clock: check combinational ready, advance model, compare registered outputs.
  task automatic step();
    #1;
    check("in_ready", in_ready, !m_valid || out_ready);
    model_edge();
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("ALUctrl", ALUctrl, m_ctrl);
      check("ALUop1", ALUop1, m_op1);
      check("ALUop2", ALUop2, m_op2);
      check("out_rd", out_rd, m_rd);
    end
    check("out_reg_write", out_reg_write, m_rw);
  endtask

  task automatic idle();
    rst = 0; in_valid = 0; in_alu_ctrl = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_alu_src = 0; in_reg_write = 0;
    flush = 0; out_ready = 1; fwd_ex_valid = 0; fwd_ex_rd = 0; fwd_ex_data = 0;
    fwd_wb_valid = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    in_valid = 1; in_alu_ctrl = op; in_rs1 = r1; in_rs2 = r2; in_rd = 5'd9;
    in_rs1_data = d1; in_rs2_data = d2; in_alu_src = 0; in_reg_write = 1;
  endtask

  initial begin
    m_valid = 0; m_rw = 0; m_imm = 0; m_ctrl = 0; m_op1 = 0; m_op2 = 0;
    m_rd = 0; m_rs1 = 0; m_rs2 = 0;
    idle();
    @(posedge clk); #1;
    rst = 1; in_valid = 1; issue(3'd1, 5'd1, 5'd2, 32'h11, 32'h22);
    step();
    check("reset out_valid", out_valid, 1'b0);
    check("reset ALUop1", ALUop1, '0);
    check("reset out_rd", out_rd, '0);
    idle();
    #1 check("ready after reset", in_ready, 1'b1);

    // basic add load
    issue(3'd0, 5'd1, 5'd2, 32'd5, 32'd7);
    step();
    check("add valid", out_valid, 1'b1);
    check("add ctrl", ALUctrl, 3'd0);
    check("add op1", ALUop1, 32'd5);
    check("add op2", ALUop2, 32'd7);

    // stall three cycles with a new beat waiting, then release
    out_ready = 0; issue(3'd2, 5'd6, 5'd7, 32'd9, 32'd10);
    repeat (3) begin
      step();
      check("stall ready", in_ready, 1'b0);
      check("stall op1", ALUop1, 32'd5);
    end
    out_ready = 1;
    step();
    check("release valid", out_valid, 1'b1);
    check("release op1", ALUop1, 32'd9);
    check("release ctrl", ALUctrl, 3'd2);

    // forwarding priority
    issue(3'd3, 5'd3, 5'd5, 32'd1, 32'd2);
    fwd_ex_valid = 1; fwd_ex_rd = 3; fwd_ex_data = 32'hAA;
    fwd_wb_valid = 1; fwd_wb_rd = 3; fwd_wb_data = 32'hBB;
    step();
`ifdef ID_EX_FWD_EN
    check("fwd ex op1", ALUop1, 32'hAA);
`else
    check("nofwd op1", ALUop1, 32'd1);
`endif
    fwd_ex_valid = 0;
    step();
`ifdef ID_EX_FWD_EN
    check("fwd wb op1", ALUop1, 32'hBB);
`else
    check("nofwd op1 b", ALUop1, 32'd1);
`endif
    in_rs1 = 0; in_rs1_data = 0; fwd_ex_valid = 1; fwd_ex_rd = 0; fwd_wb_rd = 0;
    step();
    check("x0 op1", ALUop1, 32'd0);

    // stall refresh of held rs2
    idle();
    issue(3'd4, 5'd8, 5'd4, 32'h3, 32'h10);
    step();
    idle(); out_ready = 0;
    fwd_wb_valid = 1; fwd_wb_rd = 4; fwd_wb_data = 32'h1234;
    step();
    fwd_wb_valid = 0;
    step();
`ifdef ID_EX_FWD_EN
    check("refresh op2", ALUop2, 32'h1234);
`else
    check("norefresh op2", ALUop2, 32'h10);
`endif

    // flush with held entry and incoming beat
    issue(3'd1, 5'd1, 5'd2, 32'h5, 32'h6); out_ready = 0; flush = 1;
    step();
    check("flush valid", out_valid, 1'b0);
    check("flush rw", out_reg_write, 1'b0);
    flush = 0; out_ready = 1; rst = 1;
    step();
    check("rst+acc valid", out_valid, 1'b0);
    check("rst+acc op2", ALUop2, '0);
    check("rst+acc ctrl", ALUctrl, '0);
    rst = 0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 15) == 0);
      in_valid = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 2) != 0);
      in_alu_ctrl = 3'($urandom_range(0, 4));
      in_rs1 = 5'($urandom_range(0, 4)); in_rs2 = 5'($urandom_range(0, 4));
      in_rd = 5'($urandom); in_alu_src = $urandom_range(0, 1);
      in_reg_write = $urandom_range(0, 1);
      in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom;
      fwd_ex_valid = $urandom_range(0, 1); fwd_ex_rd = 5'($urandom_range(0, 4));
      fwd_ex_data = $urandom;
      fwd_wb_valid = $urandom_range(0, 1); fwd_wb_rd = 5'($urandom_range(0, 4));
      fwd_wb_data = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
